// File: rtl/pc_pkg.sv
// Shared definitions for the program counter and its return-address stack.
// Build option PC_STK_CIRC_EN (see ret_stack) makes the return stack circular.
package pc_pkg;

    localparam int unsigned DEF_PC_W  = 4;
    localparam int unsigned DEF_OFF_W = 4;
    localparam int unsigned DEF_DEPTH = 4;

    typedef enum logic [2:0] {
        SEL_RST,
        SEL_HOLD,
        SEL_RET,
        SEL_CALL,
        SEL_JMP,
        SEL_BR,
        SEL_INC
    } pc_sel_e;

    // Sign-extend the low w bits of v to 32 bits.
    function automatic logic [31:0] sext(input logic [31:0] v, input int unsigned w);
        logic [31:0] mask;
        logic [31:0] sign;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        sign = 32'd1 << (w - 1);
        return ((v & mask) ^ sign) - sign;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO, DEPTH x W. With PC_STK_CIRC_EN defined a push while full
// overwrites the oldest entry instead of being dropped.
module ret_stack #(
    parameter  int unsigned W     = 4,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     top_c,
    output logic             full_c,
    output logic             empty_c,
    output logic [CNT_W-1:0] depth
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] head_nxt_c;
    logic [IDX_W-1:0] head_prv_c;
    logic             wr_c;
    logic             rd_c;

    // head indexes the current top; slots are used as a ring so a circular
    // overwrite of the oldest entry is just the next slot after the top.
    always_comb begin
        head_nxt_c = (head == IDX_W'(DEPTH - 1)) ? '0 : head + IDX_W'(1);
        head_prv_c = (head == '0) ? IDX_W'(DEPTH - 1) : head - IDX_W'(1);
        full_c     = (depth == CNT_W'(DEPTH));
        empty_c    = (depth == '0);
        top_c      = mem[head];
`ifdef PC_STK_CIRC_EN
        wr_c       = push;
`else
        wr_c       = push && !full_c;
`endif
        rd_c       = pop && !push && !empty_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            depth <= '0;
        end else if (wr_c) begin
            head <= head_nxt_c;
            if (!full_c) begin
                depth <= depth + CNT_W'(1);
            end
        end else if (rd_c) begin
            head  <= head_prv_c;
            depth <= depth - CNT_W'(1);
        end
    end

    // Storage is not reset; a cleared depth makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[head_nxt_c] <= din;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with hardware return-address stack: reset, hold, increment,
// relative branch, jump, call and return. Honours PC_STK_CIRC_EN via ret_stack.
module pc_stack
    import pc_pkg::*;
#(
    parameter  int unsigned PC_W    = DEF_PC_W,
    parameter  int unsigned OFF_W   = DEF_OFF_W,
    parameter  int unsigned DEPTH   = DEF_DEPTH,
    localparam int unsigned DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               set_pc,
    input  logic               stall,
    input  logic               alu_eq,
    input  logic               br,
    input  logic               jmp,
    input  logic               call,
    input  logic               ret,
    input  logic [OFF_W-1:0]   offset,
    input  logic [PC_W-1:0]    target,
    output logic [PC_W-1:0]    PC_CURR,
    output logic [DEPTH_W-1:0] stk_depth,
    output logic               stk_ovf,
    output logic               stk_unf
);

    pc_sel_e          sel_c;
    logic [PC_W-1:0]  pc_inc_c;
    logic [PC_W-1:0]  pc_br_c;
    logic [PC_W-1:0]  pc_nxt_c;
    logic [PC_W-1:0]  top_c;
    logic             full_c;
    logic             empty_c;
    logic             push_c;
    logic             pop_c;

    // One action per edge, highest priority first.
    always_comb begin
        sel_c = SEL_INC;
        if (set_pc) begin
            sel_c = SEL_RST;
        end else if (stall) begin
            sel_c = SEL_HOLD;
        end else if (ret) begin
            sel_c = SEL_RET;
        end else if (call) begin
            sel_c = SEL_CALL;
        end else if (jmp) begin
            sel_c = SEL_JMP;
        end else if (br && alu_eq) begin
            sel_c = SEL_BR;
        end
    end

    always_comb begin
        pc_inc_c = PC_CURR + PC_W'(1);
        pc_br_c  = PC_CURR + PC_W'(sext(32'(offset), OFF_W));
        push_c   = (sel_c == SEL_CALL);
        pop_c    = (sel_c == SEL_RET) && !empty_c;
        pc_nxt_c = pc_inc_c;
        case (sel_c)
            SEL_RST:  pc_nxt_c = '0;
            SEL_HOLD: pc_nxt_c = PC_CURR;
            SEL_RET:  pc_nxt_c = empty_c ? pc_inc_c : top_c;
            SEL_CALL: pc_nxt_c = target;
            SEL_JMP:  pc_nxt_c = target;
            SEL_BR:   pc_nxt_c = pc_br_c;
            default:  pc_nxt_c = pc_inc_c;
        endcase
    end

    // PC register and sticky stack-error flags.
    always_ff @(posedge clk) begin
        if (set_pc) begin
            PC_CURR <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else begin
            PC_CURR <= pc_nxt_c;
            if (sel_c == SEL_CALL && full_c) begin
                stk_ovf <= 1'b1;
            end
            if (sel_c == SEL_RET && empty_c) begin
                stk_unf <= 1'b1;
            end
        end
    end

    ret_stack #(
        .W     (PC_W),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .rst     (set_pc),
        .push    (push_c),
        .pop     (pop_c),
        .din     (pc_inc_c),
        .top_c   (top_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .depth   (stk_depth)
    );

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_pc_stack;

    localparam int unsigned PC_W  = 4;
    localparam int unsigned OFF_W = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             set_pc = 1'b0, stall = 1'b0, alu_eq = 1'b0;
    logic             br = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0;
    logic [OFF_W-1:0] offset = '0;
    logic [PC_W-1:0]  target = '0;
    logic [PC_W-1:0]  PC_CURR;
    logic [DW-1:0]    stk_depth;
    logic             stk_ovf, stk_unf;

    pc_stack #(.PC_W(PC_W), .OFF_W(OFF_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .set_pc    (set_pc),
        .stall     (stall),
        .alu_eq    (alu_eq),
        .br        (br),
        .jmp       (jmp),
        .call      (call),
        .ret       (ret),
        .offset    (offset),
        .target    (target),
        .PC_CURR   (PC_CURR),
        .stk_depth (stk_depth),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       sp, st, eq, b, j, c, r;
        int       off;
        int       tgt;
    } stim_t;

    // Reference model state
    int m_pc = 0;
    int m_stk[$];
    bit m_ovf = 0, m_unf = 0;

    int vectors = 0;
    int miscompares = 0;

    function automatic stim_t mk(bit sp, bit st, bit eq, bit b, bit j, bit c, bit r,
                                 int off, int tgt);
        stim_t s;
        s.sp = sp; s.st = st; s.eq = eq; s.b = b; s.j = j; s.c = c; s.r = r;
        s.off = off; s.tgt = tgt;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Apply one edge of stimulus and advance the model by the behavioural rules.
    task automatic step(input stim_t s);
        int soff;
        set_pc = s.sp; stall = s.st; alu_eq = s.eq; br = s.b;
        jmp = s.j; call = s.c; ret = s.r;
        offset = OFF_W'(s.off); target = PC_W'(s.tgt);
        @(posedge clk);
        #1;
        soff = s.off & 15;
        if (soff >= 8) soff -= 16;
        if (s.sp) begin
            m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
        end else if (s.st) begin
            // hold everything
        end else if (s.r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = (m_pc + 1) % 16; m_unf = 1; end
        end else if (s.c) begin
            if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % 16);
            else begin
                m_ovf = 1;
`ifdef PC_STK_CIRC_EN
                void'(m_stk.pop_front());
                m_stk.push_back((m_pc + 1) % 16);
`endif
            end
            m_pc = s.tgt & 15;
        end else if (s.j) begin
            m_pc = s.tgt & 15;
        end else if (s.b && s.eq) begin
            m_pc = (m_pc + soff + 16) % 16;
        end else begin
            m_pc = (m_pc + 1) % 16;
        end
        set_pc = 0; stall = 0; alu_eq = 0; br = 0; jmp = 0; call = 0; ret = 0;
    endtask

    task automatic test_reset();
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        vectors++;
        if (PC_CURR !== 4'd0 || stk_depth !== 3'd0 || stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: pc=%0d depth=%0d ovf=%b unf=%b expected 0 0 0 0",
                     PC_CURR, stk_depth, stk_ovf, stk_unf);
        end
        for (int i = 0; i < 16; i++) begin
            step(idle());
            vectors++;
            if (PC_CURR !== 4'((i + 1) % 16) || stk_depth !== 3'd0) begin
                miscompares++;
                $display("FAIL increment %0d: pc=%0d depth=%0d expected pc=%0d depth=0",
                         i, PC_CURR, stk_depth, (i + 1) % 16);
            end
        end
    endtask

    task automatic test_branch();
        stim_t v[4];
        int    exp_pc[4] = '{7, 15, 15, 0};
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        v[0] = mk(0, 0, 1, 1, 0, 0, 0, 7, 0);
        v[1] = mk(0, 0, 1, 1, 0, 0, 0, 8, 0);
        v[2] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0);
        v[3] = mk(0, 0, 0, 1, 0, 0, 0, 7, 0);
        foreach (v[i]) begin
            step(v[i]);
            vectors++;
            if (PC_CURR !== 4'(exp_pc[i]) || PC_CURR !== 4'(m_pc)) begin
                miscompares++;
                $display("FAIL branch %0d: pc=%0d expected %0d (model %0d)",
                         i, PC_CURR, exp_pc[i], m_pc);
            end
        end
    endtask

    task automatic test_call_ret();
        stim_t v[4];
        int    exp_pc[4]  = '{3, 9, 10, 4};
        int    exp_dep[4] = '{0, 1, 1, 0};
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        v[0] = mk(0, 0, 0, 0, 1, 0, 0, 0, 3);
        v[1] = mk(0, 0, 0, 0, 0, 1, 0, 0, 9);
        v[2] = idle();
        v[3] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
        foreach (v[i]) begin
            step(v[i]);
            vectors++;
            if (PC_CURR !== 4'(exp_pc[i]) || stk_depth !== 3'(exp_dep[i])) begin
                miscompares++;
                $display("FAIL call_ret %0d: pc=%0d depth=%0d expected pc=%0d depth=%0d",
                         i, PC_CURR, stk_depth, exp_pc[i], exp_dep[i]);
            end
        end
    endtask

    task automatic test_overflow();
`ifdef PC_STK_CIRC_EN
        int exp_pop[5] = '{2, 2, 2, 2, 3};
`else
        int exp_pop[5] = '{2, 2, 2, 1, 2};
`endif
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) step(mk(0, 0, 0, 0, 0, 1, 0, 0, 1));
        vectors++;
        if (stk_depth !== 3'd4 || stk_ovf !== 1'b1 || stk_unf !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow: depth=%0d ovf=%b unf=%b expected 4 1 0",
                     stk_depth, stk_ovf, stk_unf);
        end
        for (int i = 0; i < 5; i++) begin
            step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
            vectors++;
            if (PC_CURR !== 4'(exp_pop[i]) || stk_depth !== 3'(i < 4 ? 3 - i : 0)
                || stk_unf !== (i == 4) || stk_ovf !== 1'b1) begin
                miscompares++;
                $display("FAIL pop %0d: pc=%0d depth=%0d unf=%b ovf=%b expected pc=%0d depth=%0d unf=%b ovf=1",
                         i, PC_CURR, stk_depth, stk_unf, stk_ovf, exp_pop[i],
                         i < 4 ? 3 - i : 0, i == 4);
            end
        end
    endtask

    task automatic test_stall_reset();
        int pc0;
        int dep0;
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 11));
        pc0  = m_pc;
        dep0 = m_stk.size();
        step(mk(0, 1, 1, 1, 1, 1, 1, 5, 2));
        vectors++;
        if (PC_CURR !== 4'(pc0) || stk_depth !== 3'(dep0) || stk_ovf !== 1'b1 || stk_unf !== 1'b1) begin
            miscompares++;
            $display("FAIL stall: pc=%0d depth=%0d ovf=%b unf=%b expected pc=%0d depth=%0d 1 1",
                     PC_CURR, stk_depth, stk_ovf, stk_unf, pc0, dep0);
        end
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 5));
        vectors++;
        if (stk_depth !== 3'd2) begin
            miscompares++;
            $display("FAIL depth2: depth=%0d expected 2", stk_depth);
        end
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        vectors++;
        if (PC_CURR !== 4'd0 || stk_depth !== 3'd0 || stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: pc=%0d depth=%0d ovf=%b unf=%b expected 0 0 0 0",
                     PC_CURR, stk_depth, stk_ovf, stk_unf);
        end
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        vectors++;
        if (PC_CURR !== 4'd1 || stk_unf !== 1'b1 || stk_depth !== 3'd0) begin
            miscompares++;
            $display("FAIL ret_after_reset: pc=%0d unf=%b depth=%0d expected 1 1 0",
                     PC_CURR, stk_unf, stk_depth);
        end
    endtask

    task automatic test_priority();
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, 0, 1, 0, 0, 0, 5));
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 12));
        step(mk(0, 0, 1, 1, 1, 1, 1, 3, 9));
        vectors++;
        if (PC_CURR !== 4'd6 || stk_depth !== 3'd0 || stk_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL priority: pc=%0d depth=%0d ovf=%b expected 6 0 0",
                     PC_CURR, stk_depth, stk_ovf);
        end
        step(mk(0, 0, 1, 1, 1, 1, 0, 3, 9));
        vectors++;
        if (PC_CURR !== 4'd9 || stk_depth !== 3'd1) begin
            miscompares++;
            $display("FAIL call_over_jmp: pc=%0d depth=%0d expected 9 1", PC_CURR, stk_depth);
        end
    endtask

    task automatic test_random();
        stim_t s;
        for (int i = 0; i < 600; i++) begin
            s = mk(($urandom % 40) == 0, ($urandom % 8) == 0, 1'($urandom),
                   ($urandom % 3) == 0, ($urandom % 6) == 0, ($urandom % 4) == 0,
                   ($urandom % 4) == 0, int'($urandom % 16), int'($urandom % 16));
            step(s);
            vectors++;
            if (PC_CURR !== 4'(m_pc) || stk_depth !== 3'(m_stk.size())
                || stk_ovf !== m_ovf || stk_unf !== m_unf) begin
                miscompares++;
                $display("FAIL random %0d: pc=%0d depth=%0d ovf=%b unf=%b expected pc=%0d depth=%0d ovf=%b unf=%b",
                         i, PC_CURR, stk_depth, stk_ovf, stk_unf,
                         m_pc, m_stk.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_call_ret();
        test_overflow();
        test_stall_reset();
        test_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
